// File: rtl/basic_computer_pkg.sv
// Shared constants and types for the basic-computer control slice.
package basic_computer_pkg;

    localparam int unsigned SC_W    = 3;
    localparam int unsigned T_COUNT = 8;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_STA   = 3'd3;
    localparam logic [2:0] OP_BUN   = 3'd4;
    localparam logic [2:0] OP_BSA   = 3'd5;
    localparam logic [2:0] OP_ISZ   = 3'd6;
    localparam logic [2:0] OP_REGIO = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/seq_timing_ctrl_dec.sv
// 3-to-8 one-hot decoder shared by the timing and opcode paths.
module seq_timing_ctrl_dec
    import basic_computer_pkg::*;
(
    input  logic [SC_W-1:0]    sel,
    output logic [T_COUNT-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/seq_timing_ctrl.sv
// Sequence counter, run flip-flop and T/D/I timing qualifiers.
// Optional interrupt cycle (R flip-flop) enabled by SEQ_TIMING_INTR_CYCLE_EN.
module seq_timing_ctrl
    import basic_computer_pkg::*;
#(
    parameter int unsigned SC_WIDTH = 3,
    parameter int unsigned DECODE_T = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    input  logic                sc_clr,
    input  logic [2:0]          ir_op,
    input  logic                ir_i,
`ifdef SEQ_TIMING_INTR_CYCLE_EN
    input  logic                intr_req,
    output logic                intr_cycle,
`endif
    output logic [SC_WIDTH-1:0] sc,
    output logic                running,
    output logic [T_COUNT-1:0]  t_onehot,
    output logic [T_COUNT-1:0]  d_onehot,
    output logic                i_flag,
    output logic                reg_ref,
    output logic                io_ref,
    output logic                sc_ovf
);

    localparam logic [SC_WIDTH-1:0] DEC_SLOT   = SC_WIDTH'(DECODE_T);
    localparam logic [SC_WIDTH-1:0] INTR_LAST  = SC_WIDTH'(2);

    seq_state_e            state_q, state_d;
    logic [SC_WIDTH-1:0]   sc_q, sc_d;
    logic [T_COUNT-1:0]    d_q, d_d;
    logic                  i_q, i_d;
    logic                  ovf_q, ovf_d;
    logic [T_COUNT-1:0]    t_dec;
    logic [T_COUNT-1:0]    op_dec;
    logic                  r_active;

`ifdef SEQ_TIMING_INTR_CYCLE_EN
    logic                  r_q, r_d;
    assign r_active = r_q;
`else
    assign r_active = 1'b0;
`endif

    seq_timing_ctrl_dec u_t_dec (
        .sel    (sc_q),
        .onehot (t_dec)
    );

    seq_timing_ctrl_dec u_d_dec (
        .sel    (ir_op),
        .onehot (op_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sc_q    <= '0;
            d_q     <= '0;
            i_q     <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
            r_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            d_q     <= d_d;
            i_q     <= i_d;
            ovf_q   <= ovf_d;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
            r_q     <= r_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        d_d     = d_q;
        i_d     = i_q;
        ovf_d   = ovf_q;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        r_d     = r_q;
`endif
        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Decode latch is independent of the halt/clear priority chain.
                if (sc_q == DEC_SLOT && !r_active) begin
                    d_d = op_dec;
                    i_d = ir_i;
                end
                if (halt_req) begin
                    state_d = IDLE;
                    sc_d    = '0;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
                    r_d     = 1'b0;
`endif
                end else begin
`ifdef SEQ_TIMING_INTR_CYCLE_EN
                    if (intr_req && sc_q > INTR_LAST) begin
                        r_d = 1'b1;
                    end
                    if (r_q && sc_q == INTR_LAST) begin
                        r_d = 1'b0;
                    end
`endif
                    if (sc_clr) begin
                        sc_d = '0;
                    end else if (r_active && sc_q == INTR_LAST) begin
                        sc_d = '0;
                    end else if (sc_q == '1) begin
                        sc_d  = '0;
                        ovf_d = 1'b1;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sc_d    = '0;
            end
        endcase
    end

    always_comb begin
        running  = (state_q == RUN);
        sc       = sc_q;
        t_onehot = running ? t_dec : '0;
        d_onehot = d_q;
        i_flag   = i_q;
        reg_ref  = t_onehot[DECODE_T+1] & d_q[OP_REGIO] & ~i_q;
        io_ref   = t_onehot[DECODE_T+1] & d_q[OP_REGIO] & i_q;
        sc_ovf   = ovf_q;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        intr_cycle = r_q;
`endif
    end

endmodule

// File: tb/tb_seq_timing_ctrl.sv
// Directed plus randomized bench for seq_timing_ctrl against a behavioural model.
module tb_seq_timing_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic       sc_clr;
    logic [2:0] ir_op;
    logic       ir_i;
    logic [2:0] sc;
    logic       running;
    logic [7:0] t_onehot;
    logic [7:0] d_onehot;
    logic       i_flag;
    logic       reg_ref;
    logic       io_ref;
    logic       sc_ovf;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
    logic       intr_req;
    logic       intr_cycle;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit m_run;
    int m_sc;
    int m_d;     // latched opcode number, -1 when nothing latched
    bit m_i;
    bit m_ovf;
    bit m_r;

    seq_timing_ctrl #(
        .SC_WIDTH (3),
        .DECODE_T (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .sc_clr     (sc_clr),
        .ir_op      (ir_op),
        .ir_i       (ir_i),
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        .intr_req   (intr_req),
        .intr_cycle (intr_cycle),
`endif
        .sc         (sc),
        .running    (running),
        .t_onehot   (t_onehot),
        .d_onehot   (d_onehot),
        .i_flag     (i_flag),
        .reg_ref    (reg_ref),
        .io_ref     (io_ref),
        .sc_ovf     (sc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit st, input bit hl, input bit cl,
                                       input int op, input bit ii, input bit ir, input bit rn);
        bit new_r;
        if (!rn) begin
            m_run = 0; m_sc = 0; m_d = -1; m_i = 0; m_ovf = 0; m_r = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1;
                m_sc  = 0;
            end
        end else begin
            if (m_sc == 2 && !m_r) begin
                m_d = op;
                m_i = ii;
            end
            if (hl) begin
                m_run = 0; m_sc = 0; m_r = 0;
            end else begin
                new_r = m_r;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
                if (ir && m_sc >= 3) new_r = 1;
                if (m_r && m_sc == 2) new_r = 0;
`endif
                if (cl) m_sc = 0;
                else if (m_r && m_sc == 2) m_sc = 0;
                else if (m_sc == 7) begin
                    m_sc  = 0;
                    m_ovf = 1;
                end else m_sc = m_sc + 1;
                m_r = new_r;
            end
        end
    endfunction

    task automatic compare_all();
        logic [7:0] exp_t;
        logic [7:0] exp_d;
        exp_t = m_run ? (8'h01 << m_sc) : 8'h00;
        exp_d = (m_d < 0) ? 8'h00 : (8'h01 << m_d);
        check("sc",       {5'd0, sc},           8'(m_sc));
        check("running",  {7'd0, running},      {7'd0, m_run});
        check("t_onehot", t_onehot,             exp_t);
        check("d_onehot", d_onehot,             exp_d);
        check("i_flag",   {7'd0, i_flag},       {7'd0, m_i});
        check("reg_ref",  {7'd0, reg_ref},      {7'd0, (m_run && m_sc == 3 && m_d == 7 && !m_i)});
        check("io_ref",   {7'd0, io_ref},       {7'd0, (m_run && m_sc == 3 && m_d == 7 && m_i)});
        check("sc_ovf",   {7'd0, sc_ovf},       {7'd0, m_ovf});
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        check("intr_cycle", {7'd0, intr_cycle}, {7'd0, m_r});
`endif
    endtask

    // One clock: drive inputs, take the edge, update the model, sample outputs.
    task automatic step(input bit st, input bit hl, input bit cl, input int op,
                        input bit ii, input bit ir, input bit rn);
        start    = st;
        halt_req = hl;
        sc_clr   = cl;
        ir_op    = 3'(op);
        ir_i     = ii;
        rst_n    = rn;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        intr_req = ir;
`endif
        @(posedge clk);
        model_edge(st, hl, cl, op, ii, ir, rn);
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        m_run = 0; m_sc = 0; m_d = -1; m_i = 0; m_ovf = 0; m_r = 0;
        start = 0; halt_req = 0; sc_clr = 0; ir_op = 0; ir_i = 0; rst_n = 0;
`ifdef SEQ_TIMING_INTR_CYCLE_EN
        intr_req = 0;
`endif
        #1;

        // Reset state.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_t", t_onehot, 8'h00);
        check("rst_d", d_onehot, 8'h00);

        // IDLE ignores halt and clear.
        step(0, 1, 1, 0, 0, 0, 1);
        check("idle_run", {7'd0, running}, 8'h00);

        // Start then T0, T1, T2.
        step(1, 0, 0, 0, 0, 0, 1);
        check("start_t0", t_onehot, 8'h01);
        idle_step();
        check("t1", t_onehot, 8'h02);
        idle_step();
        check("t2", t_onehot, 8'h04);

        // Register-reference latch at T2, strobe in T3 only.
        step(0, 0, 0, 7, 0, 0, 1);
        check("t3_d", d_onehot, 8'h80);
        check("t3_reg_ref", {7'd0, reg_ref}, 8'h01);
        idle_step();
        check("t4_reg_ref", {7'd0, reg_ref}, 8'h00);

        // Clear at T4.
        step(0, 0, 1, 0, 0, 0, 1);
        check("clr_t0", t_onehot, 8'h01);
        check("clr_ovf", {7'd0, sc_ovf}, 8'h00);

        // I/O reference.
        idle_step();
        idle_step();
        step(0, 0, 0, 7, 1, 0, 1);
        check("io_ref", {7'd0, io_ref}, 8'h01);
        check("io_reg_ref", {7'd0, reg_ref}, 8'h00);

        // Wrap without clear sets sticky overflow.
        for (int k = 0; k < 5; k++) idle_step();
        check("wrap_sc", {5'd0, sc}, 8'h00);
        check("wrap_ovf", {7'd0, sc_ovf}, 8'h01);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("ovf_sticky", {7'd0, sc_ovf}, 8'h01);

        // Halt beats start at T5, then restart.
        for (int k = 0; k < 5; k++) idle_step();
        check("t5", t_onehot, 8'h20);
        step(1, 1, 0, 0, 0, 0, 1);
        check("halt_run", {7'd0, running}, 8'h00);
        check("halt_t", t_onehot, 8'h00);
        step(1, 0, 0, 0, 0, 0, 1);
        check("restart_t0", t_onehot, 8'h01);

        // Reset mid-instruction at T3.
        idle_step();
        idle_step();
        step(0, 0, 0, 7, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_mid_t", t_onehot, 8'h00);
        check("rst_mid_ovf", {7'd0, sc_ovf}, 8'h00);

`ifdef SEQ_TIMING_INTR_CYCLE_EN
        // Interrupt cycle: request at T4, clear at T5, T0..T2 as interrupt cycle.
        step(1, 0, 0, 0, 0, 0, 1);
        idle_step();
        idle_step();
        step(0, 0, 0, 7, 0, 0, 1);
        idle_step();
        step(0, 0, 0, 0, 0, 1, 1);
        check("intr_set", {7'd0, intr_cycle}, 8'h01);
        step(0, 0, 1, 0, 0, 0, 1);
        check("intr_t0", t_onehot, 8'h01);
        idle_step();
        idle_step();
        step(0, 0, 0, 3, 1, 0, 1);
        check("intr_done_sc", {5'd0, sc}, 8'h00);
        check("intr_done_r", {7'd0, intr_cycle}, 8'h00);
        check("intr_d_kept", d_onehot, 8'h80);
`endif

        // Randomized phase against the model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(3) == 0,
                 $urandom_range(15) == 0,
                 $urandom_range(5) == 0,
                 int'($urandom_range(7)),
                 $urandom_range(1) == 1,
                 $urandom_range(4) == 0,
                 $urandom_range(63) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
